// File: rtl/simd_regfile_mp.sv
// Multi-port SIMD register file: lane-masked writes, registered bypassed
// reads, a hardwired-zero entry, a reset constant entry and a pending scoreboard.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   rd_en/rd_addr           per-port read requests, sampled each edge
//   rd_data/rd_pending      registered read data and pending flag per port
//   wr_en/wr_addr           per-port write requests
//   wr_mask/wr_data         per-lane write enables and write data
//   rsv_en/rsv_addr         mark an entry pending
module simd_regfile_mp #(
  parameter int DATA_W   = 128,
  parameter int LANE_W   = 32,
  parameter int DEPTH    = 128,
  parameter int RD_PORTS = 6,
  parameter int WR_PORTS = 2,
  parameter int CONST_ADDR = 20,
  parameter logic [DATA_W-1:0] CONST_VAL =
    128'h0000_4140_0000_0000_0000_0000_0000_0000,
  localparam int LANES = DATA_W / LANE_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*AW-1:0]       rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_pending,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*AW-1:0]       wr_addr,
  input  logic [WR_PORTS*LANES-1:0]    wr_mask,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic [DATA_W-1:0] byp_data [RD_PORTS];
  logic [RD_PORTS-1:0] byp_pend;

  // Array update: later ports overwrite earlier ones lane by lane,
  // so the highest-indexed port wins a shared lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= (e == CONST_ADDR) ? CONST_VAL : '0;
      end
    end else begin
      for (int p = 0; p < WR_PORTS; p++) begin
        for (int l = 0; l < LANES; l++) begin
          if (wr_en[p] && wr_mask[p*LANES+l] &&
              wr_addr[p*AW +: AW] != '0) begin
            mem[wr_addr[p*AW +: AW]][l*LANE_W +: LANE_W] <=
              wr_data[p*DATA_W + l*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // Scoreboard: write clears, reserve applied last so it wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && |wr_mask[p*LANES +: LANES] &&
            wr_addr[p*AW +: AW] != '0) begin
          pend[wr_addr[p*AW +: AW]] <= 1'b0;
        end
      end
      if (rsv_en && rsv_addr != '0) begin
        pend[rsv_addr] <= 1'b1;
      end
    end
  end

  // Bypass: reproduce this edge's next-state value of the read entry.
  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      byp_data[i] = mem[rd_addr[i*AW +: AW]];
      byp_pend[i] = pend[rd_addr[i*AW +: AW]];
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW]) begin
          for (int l = 0; l < LANES; l++) begin
            if (wr_mask[p*LANES+l]) begin
              byp_data[i][l*LANE_W +: LANE_W] =
                wr_data[p*DATA_W + l*LANE_W +: LANE_W];
            end
          end
          if (|wr_mask[p*LANES +: LANES]) begin
            byp_pend[i] = 1'b0;
          end
        end
      end
      if (rsv_en && rsv_addr == rd_addr[i*AW +: AW]) begin
        byp_pend[i] = 1'b1;
      end
      if (rd_addr[i*AW +: AW] == '0) begin
        byp_data[i] = '0;
        byp_pend[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data    <= '0;
      rd_pending <= '0;
    end else begin
      for (int i = 0; i < RD_PORTS; i++) begin
        rd_data[i*DATA_W +: DATA_W] <= rd_en[i] ? byp_data[i] : '0;
        rd_pending[i] <= rd_en[i] & byp_pend[i];
      end
    end
  end

endmodule

// File: tb/tb_simd_regfile_mp.sv
// Directed bench for simd_regfile_mp: reset, masked writes, collisions,
// zero entry, scoreboard and asynchronous mid-run reset.
module tb_simd_regfile_mp;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int NR = 6;
  localparam int NW = 2;
  localparam int LN = 4;
  localparam logic [DW-1:0] CV =
    128'h0000_4140_0000_0000_0000_0000_0000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      rd_en;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_pending;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*LN-1:0]   wr_mask;
  logic [NW*DW-1:0]   wr_data;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;

  int tests = 0;
  int fails = 0;

  simd_regfile_mp dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic rd(input int i, input int a);
    rd_en[i] = 1'b1;
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [LN-1:0] m,
                    input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_mask[p*LN +: LN] = m;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [DW-1:0] port(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  logic [DW-1:0] a_v, b_v, d3, d20;

  initial begin
    a_v = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    b_v = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    d3  = 128'h33333333_44444444_55555555_66666666;
    d20 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", DW'(rd_data == '0), 1);
    chk("reset_pend", DW'(rd_pending), 0);
    @(negedge clk);
    reset = 1'b0;

    // reset contents
    rd(0, 0); rd(1, 20); rd(2, 1); rd(3, 2); rd(4, 3); rd(5, 127);
    step();
    chk("init_a0", port(0), 0);
    chk("init_a20", port(1), CV);
    chk("init_a1", port(2), 0);
    chk("init_a2", port(3), 0);
    chk("init_a3", port(4), 0);
    chk("init_a127", port(5), 0);
    chk("init_pend", DW'(rd_pending), 0);

    // masked merge over two cycles
    wr(0, 5, 4'b1111, {4{32'h11111111}});
    step();
    wr(1, 5, 4'b0101, {4{32'hFFFFFFFF}});
    step();
    rd(0, 5);
    step();
    chk("mask_merge", port(0),
        128'h11111111_FFFFFFFF_11111111_FFFFFFFF);

    // same-cycle collision with bypassed read; port 1 disabled
    wr(0, 9, 4'b1111, a_v);
    wr(1, 9, 4'b0011, b_v);
    rd(2, 9);
    rd_addr[1*AW +: AW] = 7'd20;
    step();
    chk("collide_byp", port(2),
        128'hA3A3A3A3_A2A2A2A2_B1B1B1B1_B0B0B0B0);
    chk("rd_disabled", port(1), 0);
    rd(3, 9);
    step();
    chk("collide_arr", port(3),
        128'hA3A3A3A3_A2A2A2A2_B1B1B1B1_B0B0B0B0);

    // entry 0 ignores writes and reservations
    wr(0, 0, 4'b1111, '1);
    rsv_en = 1'b1; rsv_addr = 7'd0;
    rd(0, 0);
    step();
    chk("zero_byp", port(0), 0);
    chk("zero_pend", DW'(rd_pending[0]), 0);
    rd(0, 0);
    step();
    chk("zero_arr", port(0), 0);

    // scoreboard
    rsv_en = 1'b1; rsv_addr = 7'd7;
    step();
    rd(4, 7);
    step();
    chk("rsv_pend", DW'(rd_pending[4]), 1);
    wr(0, 7, 4'b0000, '1);
    rd(4, 7);
    step();
    chk("mask0_pend", DW'(rd_pending[4]), 1);
    chk("mask0_data", port(4), 0);
    wr(1, 7, 4'b0001, 128'h5A5A5A5A);
    rd(4, 7);
    step();
    chk("wr_clr_pend", DW'(rd_pending[4]), 0);
    chk("wr_clr_data", port(4), 128'h5A5A5A5A);
    wr(0, 7, 4'b0010, 128'h77777777_00000000);
    rsv_en = 1'b1; rsv_addr = 7'd7;
    rd(4, 7);
    step();
    chk("rsv_wins", DW'(rd_pending[4]), 1);
    chk("rsv_wr_data", port(4), 128'h77777777_5A5A5A5A);
    rd(5, 7);
    step();
    chk("rsv_wins_hold", DW'(rd_pending[5]), 1);

    // asynchronous reset mid-run
    wr(0, 3, 4'b1111, d3);
    wr(1, 20, 4'b1111, d20);
    step();
    rsv_en = 1'b1; rsv_addr = 7'd3;
    step();
    rd(0, 3); rd(1, 20);
    step();
    chk("pre_rst_d3", port(0), d3);
    chk("pre_rst_p3", DW'(rd_pending[0]), 1);
    chk("pre_rst_d20", port(1), d20);
    #2;
    reset = 1'b1;
    #1;
    chk("async_data", DW'(rd_data == '0), 1);
    chk("async_pend", DW'(rd_pending), 0);
    rd(0, 3); rd(1, 20);
    wr(0, 3, 4'b1111, '1);
    @(posedge clk);
    @(negedge clk);
    wr_en = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_d3", port(0), 0);
    chk("post_rst_d20", port(1), CV);
    chk("post_rst_pend", DW'(rd_pending[1:0]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
